// File: rtl/gpu_pkg.sv
// Shared GPU types: VRAM write entry, default queue depth and write-queue FSM states.
// VRAM_ADDR_WIDTH may be supplied by the build; it falls back to a 1 KiB VRAM (10 bits).
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

package gpu_pkg;

    localparam int VRAM_ADDR_W   = `VRAM_ADDR_WIDTH;
    localparam int DEPTH_DEFAULT = 16;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] address;
        logic [7:0]             data;
    } vram_wr_entry_t;

    typedef enum logic [1:0] {
        WAIT,
        SETTLE,
        DRAIN
    } wq_state_e;

endpackage

// File: rtl/vram_wq_fifo_m.sv
// Single-clock FIFO with same-cycle push/pop; the caller qualifies push/pop against full/empty.
// The head entry is presented combinationally so the caller's output register acts as the read register.
module vram_wq_fifo_m #(
    parameter int WIDTH     = 18,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_i && !pop_i)      count_d = count_q + CNT_WIDTH'(1);
        else if (pop_i && !push_i) count_d = count_q - CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vram_write_queue_m.sv
// Defers CPU VRAM stores into a FIFO and replays them only inside the video writable window.
// Define VRAM_WRITE_QUEUE_BYPASS_EN to let a push into an empty queue during DRAIN skip the FIFO.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

module vram_write_queue_m
    import gpu_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [7:0]            cpu_data,
    input  logic                  cpu_write_enable,
    input  logic                  SELECT_vram,
    input  logic                  writable,
    input  logic                  clr_overflow,
    output logic [ADDR_WIDTH-1:0] vram_address,
    output logic [7:0]            vram_data,
    output logic                  vram_write_enable,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  drained
);

    localparam int ENTRY_W = ADDR_WIDTH + 8;

    wq_state_e             state_q, state_d;
    logic                  push_req, pop, bypass, fifo_push, drop;
    logic [ENTRY_W-1:0]    head;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  ovf_q, ovf_d;
    logic                  drained_q, drained_d;

    vram_wq_fifo_m #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .pop_i   (pop),
        .wdata_i ({cpu_address, cpu_data}),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    if (writable) state_d = SETTLE;
            // One idle cycle lets the GPU switch its internal buffers before the first write.
            SETTLE:  state_d = writable ? DRAIN : WAIT;
            DRAIN:   if (!writable) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        push_req = cpu_write_enable & SELECT_vram;
        pop      = (state_q == DRAIN) & writable & ~empty;
`ifdef VRAM_WRITE_QUEUE_BYPASS_EN
        // Only legal with an empty queue, so push order is never violated.
        bypass   = (state_q == DRAIN) & writable & empty & push_req;
`else
        bypass   = 1'b0;
`endif
        // A full queue still accepts a push when a pop frees a slot in the same cycle.
        fifo_push = push_req & ~bypass & (~full | pop);
        drop      = push_req & full & ~pop;
        drained_d = pop & ~push_req & (count == CNT_WIDTH'(1));

        wen_d  = pop | bypass;
        addr_d = addr_q;
        data_d = data_q;
        if (pop) begin
            addr_d = head[ENTRY_W-1:8];
            data_d = head[7:0];
        end else if (bypass) begin
            addr_d = cpu_address;
            data_d = cpu_data;
        end

        // A dropped push outranks a coincident clear so no loss goes unreported.
        ovf_d = ovf_q;
        if (drop)              ovf_d = 1'b1;
        else if (clr_overflow) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WAIT;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            drained_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            drained_q <= drained_d;
        end
    end

    assign vram_write_enable = wen_q;
    assign vram_address      = addr_q;
    assign vram_data         = data_q;
    assign overflow          = ovf_q;
    assign drained           = drained_q;

endmodule

// File: tb/tb_vram_write_queue_m.sv
// Directed and randomized checks of vram_write_queue_m against a queue-based window model.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 10
`endif

module tb_vram_write_queue_m;

    localparam int DEPTH = 16;
    localparam int AW    = `VRAM_ADDR_WIDTH;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef VRAM_WRITE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [7:0]    cpu_data = '0;
    logic          cpu_write_enable = 1'b0;
    logic          SELECT_vram = 1'b0;
    logic          writable = 1'b0;
    logic          clr_overflow = 1'b0;
    logic [AW-1:0] vram_address;
    logic [7:0]    vram_data;
    logic          vram_write_enable;
    logic          full, empty, overflow, drained;
    logic [CW-1:0] count;

    vram_write_queue_m #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_address       (cpu_address),
        .cpu_data          (cpu_data),
        .cpu_write_enable  (cpu_write_enable),
        .SELECT_vram       (SELECT_vram),
        .writable          (writable),
        .clr_overflow      (clr_overflow),
        .vram_address      (vram_address),
        .vram_data         (vram_data),
        .vram_write_enable (vram_write_enable),
        .full              (full),
        .empty             (empty),
        .count             (count),
        .overflow          (overflow),
        .drained           (drained)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;

    // Reference: a write is replayed in cycle t only if writable has been high for
    // three consecutive cycles ending at t (rise, settle, then drain).
    ent_t          q[$];
    int            run;
    logic          exp_wen, exp_ovf, exp_drained;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_data;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        run         = 0;
        exp_wen     = 1'b0;
        exp_addr    = '0;
        exp_data    = '0;
        exp_ovf     = 1'b0;
        exp_drained = 1'b0;
    endtask

    task automatic model_step();
        int   pre;
        bit   push, win, pop, byp, drop;
        ent_t e;
        pre  = q.size();
        push = cpu_write_enable & SELECT_vram;
        run  = writable ? run + 1 : 0;
        win  = (run >= 3);
        pop  = win && (pre > 0);
        byp  = BYP && win && (pre == 0) && push;
        drop = 1'b0;
        exp_drained = pop && (pre == 1) && !push;
        if (pop) begin
            e = q.pop_front();
            exp_wen = 1'b1; exp_addr = e.a; exp_data = e.d;
        end else if (byp) begin
            exp_wen = 1'b1; exp_addr = cpu_address; exp_data = cpu_data;
        end else begin
            exp_wen = 1'b0;
        end
        if (push && !byp) begin
            if (pre < DEPTH || pop) begin
                e.a = cpu_address; e.d = cpu_data;
                q.push_back(e);
            end else begin
                drop = 1'b1;
            end
        end
        if (drop)              exp_ovf = 1'b1;
        else if (clr_overflow) exp_ovf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wen"},     32'(vram_write_enable), 32'(exp_wen));
        chk({tag, ".addr"},    32'(vram_address),      32'(exp_addr));
        chk({tag, ".data"},    32'(vram_data),         32'(exp_data));
        chk({tag, ".count"},   32'(count),             32'(q.size()));
        chk({tag, ".full"},    32'(full),              32'(q.size() == DEPTH));
        chk({tag, ".empty"},   32'(empty),             32'(q.size() == 0));
        chk({tag, ".ovf"},     32'(overflow),          32'(exp_ovf));
        chk({tag, ".drained"}, 32'(drained),           32'(exp_drained));
    endtask

    // One clock: drive inputs at the falling edge, step the model, check at the next falling edge.
    task automatic cycle(input string tag, input logic we, input logic sel, input logic wr,
                         input logic clr, input logic [AW-1:0] a, input logic [7:0] d);
        cpu_write_enable = we;
        SELECT_vram      = sel;
        writable         = wr;
        clr_overflow     = clr;
        cpu_address      = a;
        cpu_data         = d;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
        if (vram_write_enable === 1'b1) wr_seen++;
        $display("%s we=%0b wr=%0b wen=%0b addr=%0h data=%0h count=%0d ovf=%0b drn=%0b",
                 tag, we & sel, wr, vram_write_enable, vram_address, vram_data, count, overflow, drained);
    endtask

    task automatic idle(input string tag, input logic wr, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, wr, 1'b0, '0, '0);
    endtask

    initial begin
        logic wr_r;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // Stores outside the window are held.
        cycle("push_a", 1'b1, 1'b1, 1'b0, 1'b0, AW'('h010), 8'hAA);
        cycle("push_b", 1'b1, 1'b1, 1'b0, 1'b0, AW'('h011), 8'hBB);
        cycle("push_c", 1'b1, 1'b1, 1'b0, 1'b0, AW'('h010), 8'hCC);
        chk("held_count", 32'(count), 32'd3);
        chk("held_wen", 32'(vram_write_enable), 32'd0);

        // Window opens: settle, three in-order writes, drained pulse.
        idle("window1", 1'b1, 6);
        chk("window1_empty", 32'(empty), 32'd1);
        idle("close1", 1'b0, 2);

        // Overfill to 17 while closed.
        for (int i = 0; i < 17; i++)
            cycle("fill", 1'b1, 1'b1, 1'b0, 1'b0, AW'(32'h100 + i), 8'(8'h40 + i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd1);
        cycle("clr_ovf", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        chk("clr_ovf_val", 32'(overflow), 32'd0);

        // Window of seven cycles yields five pops; the last write lands after the fall.
        wr_seen = 0;
        idle("part_drain", 1'b1, 7);
        idle("part_close", 1'b0, 3);
        chk("part_writes", 32'(wr_seen), 32'd5);
        chk("part_count", 32'(count), 32'd11);
        idle("resume", 1'b1, 3);
        chk("resume_addr", 32'(vram_address), 32'h105);
        idle("resume_close", 1'b0, 2);

        // Refill to full, then push in the same cycle as a pop.
        for (int i = 0; i < 6; i++)
            cycle("refill", 1'b1, 1'b1, 1'b0, 1'b0, AW'(32'h200 + i), 8'(8'h80 + i));
        chk("refill_full", 32'(full), 32'd1);
        idle("settle2", 1'b1, 2);
        cycle("push_pop", 1'b1, 1'b1, 1'b1, 1'b0, AW'('h2AA), 8'h77);
        chk("push_pop_count", 32'(count), 32'd16);
        chk("push_pop_ovf", 32'(overflow), 32'd0);
        idle("drain8", 1'b1, 8);
        chk("mid_count", 32'(count), 32'd8);
        chk("mid_wen", 32'(vram_write_enable), 32'd1);

        // Asynchronous reset in the middle of a drain.
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_wen", 32'(vram_write_enable), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        @(negedge clk);
        check_all("in_reset");
        rst = 1'b1;
        cycle("post_rst_push", 1'b1, 1'b1, 1'b1, 1'b0, AW'('h033), 8'h11);
        cycle("post_rst_push", 1'b1, 1'b1, 1'b1, 1'b0, AW'('h034), 8'h22);
        idle("post_rst", 1'b1, 4);

        // Empty queue in DRAIN: latency 1 with bypass, 2 without.
        cycle("byp_push", 1'b1, 1'b1, 1'b1, 1'b0, AW'('h3FF), 8'h5A);
        chk("byp_n1_wen", 32'(vram_write_enable), 32'(BYP));
        chk("byp_n1_count", 32'(count), 32'(!BYP));
        idle("byp_after", 1'b1, 1);
        chk("byp_n2_wen", 32'(vram_write_enable), 32'(!BYP));
        idle("byp_tail", 1'b1, 2);

        // Randomized traffic with windows of varying length.
        wr_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) wr_r = ~wr_r;
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) != 0), wr_r,
                  1'($urandom_range(0, 15) == 0), AW'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_write_queue_m.md
Name: vram_write_queue_m

Overview:
- Sits directly upstream of the GPU's VRAM write port.
- Captures CPU VRAM writes at any time into a FIFO of {address, data} entries.
- Drains those entries into VRAM only while the video timing reports the writable window.
- Result: CPU stores made outside the writable window are deferred, not lost, and VRAM is never modified mid-scanout.

Parameters:
- DEPTH, 16, FIFO entries; power of two, range 2..64.
- ADDR_WIDTH, `VRAM_ADDR_WIDTH, width of a VRAM address.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  GPU pixel clock (12.5875 MHz).
- rst  input  1  reset; asynchronous, active-low.
- cpu_address  input  ADDR_WIDTH  CPU bus address.
- cpu_data  input  8  CPU write data.
- cpu_write_enable  input  1  CPU write strobe, one cycle per write.
- SELECT_vram  input  1  address decoder hit for the VRAM range.
- writable  input  1  high while VRAM may be modified; from video timing.
- clr_overflow  input  1  one-cycle pulse that clears the overflow flag.
- vram_address  output  ADDR_WIDTH  address toward the GPU VRAM port.
- vram_data  output  8  data toward the GPU VRAM port.
- vram_write_enable  output  1  one-cycle write strobe into VRAM.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  CNT_WIDTH  occupancy.
- overflow  output  1  sticky; a write was dropped.
- drained  output  1  one-cycle pulse when a drain empties the FIFO.

Behaviour:
- Reset (rst low, async):
  - pointers and count = 0; empty=1, full=0.
  - vram_write_enable=0, vram_address=0, vram_data=0.
  - overflow=0, drained=0; FSM = WAIT.
- Push: push = cpu_write_enable & SELECT_vram.
  - Accepted when !full, or when full and a pop occurs in the same cycle (count unchanged).
  - Push while full with no pop: entry dropped, overflow<=1.
- Overflow flag:
  - Cleared by clr_overflow.
  - If a dropped push and clr_overflow coincide, set wins.
- FSM:
  - WAIT: no pops. Go to SETTLE when writable=1.
  - SETTLE: exactly one idle cycle, giving the GPU's internal buffers time to switch. Go to DRAIN if writable=1, else WAIT.
  - DRAIN: pop = !empty & writable. Go to WAIT when writable=0.
- Write issue:
  - A pop at cycle N registers the head entry onto vram_address/vram_data with vram_write_enable=1 at N+1.
  - Back-to-back pops are allowed: one VRAM write per cycle.
  - vram_address/vram_data hold their last values while vram_write_enable=0.
- End of window:
  - A write issued in the last writable cycle still appears one cycle later; the GPU tolerates one trailing write.
  - No pop occurs in any cycle where writable=0.
- Minimum latency: push at N with FIFO empty and FSM in DRAIN: pop at N+1, vram_write_enable at N+2.
- Ordering: entries are written strictly in push order; no coalescing, duplicate addresses written twice.
- drained pulses at N+1 when a pop at N takes count from 1 to 0 (pop alone, no same-cycle push).
- Count arithmetic:
  - push&pop leaves count unchanged; push alone +1; pop alone -1.
  - Pointers wrap modulo DEPTH.
- Reset mid-drain: queued entries are discarded and vram_write_enable drops immediately (async).

Optional Feature:
- Macro: VRAM_WRITE_QUEUE_BYPASS_EN.
- Defined:
  - In DRAIN with empty=1 and writable=1, an accepted push skips the FIFO.
  - It is registered straight onto the outputs: vram_write_enable at N+1.
  - Count unchanged; drained does not pulse.
  - Ordering is preserved because bypass only occurs when the FIFO is empty.
- Undefined: every write passes through the FIFO (minimum latency 2).

Decomposition:
- Shared package gpu_pkg:
  - vram_wr_entry_t typedef {address[ADDR_WIDTH], data[8]}.
  - DEPTH default constant.
  - FSM state enum {WAIT, SETTLE, DRAIN}.
- Sub-module vram_wq_fifo_m: synchronous single-clock FIFO with storage, pointers, count, full/empty and same-cycle push/pop.
- Top level holds the FSM, output registers, overflow, drained and the bypass path.

Test Plan:
- Reset, writable=0, push 3 writes (0x010/0xAA, 0x011/0xBB, 0x010/0xCC) -> count=3, no vram_write_enable.
- Then raise writable -> one SETTLE cycle, three consecutive strobes in that order, drained pulse, empty=1.
- writable=0, push 17 writes at DEPTH=16 -> full=1 after 16, 17th dropped, overflow=1, count=16.
  - Pulse clr_overflow -> overflow=0.
- Drain 16 entries with writable dropping after 5 pops -> exactly 5 writes, the 5th one cycle after the fall, count=11.
  - Next window resumes with entry 6.
- Full FIFO in DRAIN, push in the same cycle as a pop -> push accepted, count stays 16, overflow stays 0.
- Assert rst low mid-drain (count=8) -> vram_write_enable=0 immediately, count=0.
  - After release: no writes until the next writable rise plus SETTLE.
- With VRAM_WRITE_QUEUE_BYPASS_EN, empty FIFO in DRAIN, push 0x3FF/0x5A at N -> vram_write_enable=1 at N+1, count stays 0; without the macro the strobe is at N+2.
